// File: rtl/iob_ila_capture.sv
// iob_ila_capture: single-shot logic-analyser capture engine.
// Keeps a configurable number of pre-trigger samples in a circular buffer,
// then fills the rest after a masked edge/level trigger. Results are read out
// in chronological order once the capture is done.
module iob_ila_capture #(
   parameter int SIGNAL_W  = 32,
   parameter int TRIGGER_W = 4,
   parameter int BUFFER_W  = 8,
   parameter int EDGE_EN   = 1
) (
   input  logic                  clk_i,
   input  logic                  arst_n_i,
   input  logic                  cke_i,
   input  logic [SIGNAL_W-1:0]   signal_i,
   input  logic [TRIGGER_W-1:0]  trigger_i,
   input  logic [TRIGGER_W-1:0]  trig_type_i,
   input  logic [TRIGGER_W-1:0]  trig_negate_i,
   input  logic [TRIGGER_W-1:0]  trig_mask_i,
   input  logic                  trig_and_i,
   input  logic [BUFFER_W-1:0]   pre_len_i,
   input  logic                  arm_i,
   input  logic                  abort_i,
   output logic [2:0]            state_o,
   output logic                  done_o,
   output logic [BUFFER_W:0]     n_samples_o,
   output logic [BUFFER_W-1:0]   trig_pos_o,
   input  logic                  rd_en_i,
   input  logic [BUFFER_W-1:0]   rd_idx_i,
   output logic                  rd_valid_o,
   output logic [SIGNAL_W-1:0]   rd_data_o
);

   localparam int DEPTH = 2 ** BUFFER_W;
   localparam logic [BUFFER_W:0]   DEPTH_C  = (BUFFER_W+1)'(DEPTH);
   localparam logic [BUFFER_W:0]   CNT_ONE  = (BUFFER_W+1)'(1);
   localparam logic [BUFFER_W-1:0] PTR_ONE  = BUFFER_W'(1);
   localparam logic [BUFFER_W-1:0] DEPTH_M1 = '1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_WAIT = 3'd2,
      ST_POST = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t                state;
   logic [BUFFER_W-1:0]   wp;
   logic [BUFFER_W:0]     cnt;
   logic [BUFFER_W-1:0]   pl;
   logic [BUFFER_W-1:0]   post_cnt;
   logic [BUFFER_W-1:0]   trig_addr;
   logic [TRIGGER_W-1:0]  t_prev;
   logic [SIGNAL_W-1:0]   mem [DEPTH];

   logic [TRIGGER_W-1:0]  t_cur;
   logic [TRIGGER_W-1:0]  edge_sel;
   logic [TRIGGER_W-1:0]  cond;
   logic                  hit;
   logic                  wr_en;
   logic [BUFFER_W-1:0]   post_len;
   logic [BUFFER_W-1:0]   rd_addr;

   // Sample count saturates at the buffer depth once the ring has wrapped.
   function automatic logic [BUFFER_W:0] sat_inc(input logic [BUFFER_W:0] v);
      return (v == DEPTH_C) ? v : v + CNT_ONE;
   endfunction

   // Pre-trigger samples actually available: the requested length, unless
   // fewer samples had been written when the trigger fired.
   function automatic logic [BUFFER_W-1:0] min_pos(input logic [BUFFER_W-1:0] req,
                                                    input logic [BUFFER_W:0]   have);
      return ({1'b0, req} <= have) ? req : have[BUFFER_W-1:0];
   endfunction

   // Trigger evaluation: inversion, optional rising-edge detect, then masked AND/OR.
   always_comb begin
      t_cur    = trigger_i ^ trig_negate_i;
      edge_sel = (EDGE_EN != 0) ? trig_type_i : '0;
      cond     = (edge_sel & t_cur & ~t_prev) | (~edge_sel & t_cur);
      hit      = 1'b0;
      if (trig_mask_i != '0)
         hit = trig_and_i ? ((cond & trig_mask_i) == trig_mask_i) : |(cond & trig_mask_i);
   end

   // Post-trigger length is DEPTH-1-PL; pre_len's width already bounds PL to DEPTH-1.
   assign post_len = DEPTH_M1 - pl;
   assign rd_addr  = (trig_addr - trig_pos_o) + rd_idx_i;
   assign wr_en    = cke_i && !arm_i && !abort_i &&
                     ((state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST));

   assign state_o     = state;
   assign n_samples_o = cnt;

   // Sample buffer write port; contents are deliberately left unreset.
   always_ff @(posedge clk_i) begin
      if (wr_en)
         mem[wp] <= signal_i;
   end

   // Capture FSM, trigger history and registered readout.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state      <= ST_IDLE;
         done_o     <= 1'b0;
         cnt        <= '0;
         trig_pos_o <= '0;
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
         wp         <= '0;
         pl         <= '0;
         post_cnt   <= '0;
         trig_addr  <= '0;
         t_prev     <= '0;
      end else if (cke_i) begin
         t_prev     <= t_cur;
         rd_valid_o <= rd_en_i;
         if (rd_en_i)
            rd_data_o <= (state == ST_DONE) ? mem[rd_addr] : '0;

         if (arm_i) begin
            pl         <= pre_len_i;
            wp         <= '0;
            cnt        <= '0;
            done_o     <= 1'b0;
            trig_pos_o <= '0;
            post_cnt   <= '0;
            state      <= (pre_len_i == '0) ? ST_WAIT : ST_PRE;
         end else if (abort_i) begin
            state  <= ST_IDLE;
            done_o <= 1'b0;
         end else begin
            case (state)
               ST_PRE: begin
                  wp  <= wp + PTR_ONE;
                  cnt <= sat_inc(cnt);
                  if ((cnt + CNT_ONE) == {1'b0, pl})
                     state <= ST_WAIT;
               end
               ST_WAIT: begin
                  wp  <= wp + PTR_ONE;
                  cnt <= sat_inc(cnt);
                  if (hit) begin
                     trig_addr  <= wp;
                     trig_pos_o <= min_pos(pl, cnt);
                     post_cnt   <= '0;
                     if (pl == DEPTH_M1) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                     end else begin
                        state <= ST_POST;
                     end
                  end
               end
               ST_POST: begin
                  wp       <= wp + PTR_ONE;
                  cnt      <= sat_inc(cnt);
                  post_cnt <= post_cnt + PTR_ONE;
                  if ((post_cnt + PTR_ONE) == post_len) begin
                     state  <= ST_DONE;
                     done_o <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iob_ila_capture.sv
// Directed bench for iob_ila_capture with an 8-entry buffer and a 16-bit bus.
module tb_iob_ila_capture;

   localparam int SW = 16;
   localparam int TW = 4;
   localparam int BW = 3;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic          cke = 1'b1;
   logic [SW-1:0] sig = '0;
   logic [TW-1:0] trigger = '0;
   logic [TW-1:0] trig_type = '0;
   logic [TW-1:0] trig_negate = '0;
   logic [TW-1:0] trig_mask = '0;
   logic          trig_and = 1'b0;
   logic [BW-1:0] pre_len = '0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic [2:0]    state;
   logic          done;
   logic [BW:0]   n_samples;
   logic [BW-1:0] trig_pos;
   logic          rd_en = 1'b0;
   logic [BW-1:0] rd_idx = '0;
   logic          rd_valid;
   logic [SW-1:0] rd_data;

   int checks = 0;
   int errors = 0;

   iob_ila_capture #(
      .SIGNAL_W (SW),
      .TRIGGER_W(TW),
      .BUFFER_W (BW),
      .EDGE_EN  (1)
   ) dut (
      .clk_i        (clk),
      .arst_n_i     (arst_n),
      .cke_i        (cke),
      .signal_i     (sig),
      .trigger_i    (trigger),
      .trig_type_i  (trig_type),
      .trig_negate_i(trig_negate),
      .trig_mask_i  (trig_mask),
      .trig_and_i   (trig_and),
      .pre_len_i    (pre_len),
      .arm_i        (arm),
      .abort_i      (abort),
      .state_o      (state),
      .done_o       (done),
      .n_samples_o  (n_samples),
      .trig_pos_o   (trig_pos),
      .rd_en_i      (rd_en),
      .rd_idx_i     (rd_idx),
      .rd_valid_o   (rd_valid),
      .rd_data_o    (rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           pl;
      logic [TW-1:0] typ;
      logic [TW-1:0] neg;
      logic [TW-1:0] mask;
      logic          andm;
      logic          hold;
      logic [TW-1:0] idle;
      logic [TW-1:0] hitp;
      int            delay;
      int            e_first;
      int            e_pos;
      int            e_post;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One clock; inputs change 1 time unit after the edge, the bus counts up.
   task automatic step();
      @(posedge clk);
      #1;
      sig = sig + 1'b1;
   endtask

   // Arm and make the first captured sample carry the value 3.
   task automatic arm_cap(input int pl);
      pre_len = BW'(pl);
      arm = 1'b1;
      step();
      arm = 1'b0;
      sig = 16'd3;
   endtask

   task automatic read_seq(input string name, input int first);
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rd_idx = BW'(i);
         step();
         check({name, "_rdv"}, 32'(rd_valid), 32'd1);
         check({name, "_rdd"}, 32'(rd_data), 32'(first + i));
      end
      rd_en = 1'b0;
      step();
      check({name, "_rdv_off"}, 32'(rd_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [SW-1:0] exp_c [8];

      tbl[0] = '{2, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 0, 3, 2, 5};
      tbl[1] = '{5, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0001, 0, 3, 5, 2};
      tbl[2] = '{5, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 3, 6, 5, 2};
      tbl[3] = '{3, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 1, 4, 3, 4};
      tbl[4] = '{7, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 0, 3, 7, 0};
      tbl[5] = '{1, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b1000, 2, 5, 1, 6};
      tbl[6] = '{0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0010, 4, 7, 0, 7};

      // reset state
      #12;
      check("rst_state", 32'(state), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_nsamp", 32'(n_samples), 32'd0);
      check("rst_rdv", 32'(rd_valid), 32'd0);
      arst_n = 1'b1;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("idle_read_v", 32'(rd_valid), 32'd1);
      check("idle_read_d", 32'(rd_data), 32'd0);

      // table-driven captures
      for (int v = 0; v < 7; v++) begin
         string nm;
         nm = $sformatf("vec%0d", v);
         trig_type   = tbl[v].typ;
         trig_negate = tbl[v].neg;
         trig_mask   = tbl[v].mask;
         trig_and    = tbl[v].andm;
         trigger     = tbl[v].hold ? tbl[v].hitp : tbl[v].idle;
         arm_cap(tbl[v].pl);
         repeat (tbl[v].pl) step();
         check({nm, "_wait"}, 32'(state), 32'd2);
         if (!tbl[v].hold) begin
            repeat (tbl[v].delay) step();
            trigger = tbl[v].hitp;
         end
         step();
         trigger = tbl[v].idle;
         if (tbl[v].e_post == 0) begin
            check({nm, "_done_now"}, 32'(done), 32'd1);
         end else begin
            check({nm, "_post"}, 32'(state), 32'd3);
            repeat (tbl[v].e_post - 1) step();
            check({nm, "_early"}, 32'(done), 32'd0);
            step();
            check({nm, "_done"}, 32'(done), 32'd1);
         end
         check({nm, "_state"}, 32'(state), 32'd4);
         check({nm, "_tpos"}, 32'(trig_pos), 32'(tbl[v].e_pos));
         check({nm, "_nsamp"}, 32'(n_samples), 32'd8);
         read_seq(nm, tbl[v].e_first);
      end

      // edge trigger, PL=0, trigger already high before arm
      trig_type = 4'b0001; trig_negate = '0; trig_mask = 4'b0001; trig_and = 1'b0;
      trigger = 4'b0001;
      step(); step();
      arm_cap(0);
      check("edge_wait", 32'(state), 32'd2);
      repeat (3) step();
      check("edge_no_hit", 32'(state), 32'd2);
      trigger = 4'b0000; step();
      trigger = 4'b0001; step();
      check("edge_hit", 32'(state), 32'd3);
      repeat (6) step();
      check("edge_early", 32'(done), 32'd0);
      step();
      check("edge_done", 32'(done), 32'd1);
      check("edge_tpos", 32'(trig_pos), 32'd0);
      read_seq("edge", 7);

      // AND mode, bits on separate cycles then together
      trig_type = '0; trig_mask = 4'b0011; trig_and = 1'b1; trigger = '0;
      arm_cap(1);
      step();
      check("and_wait", 32'(state), 32'd2);
      trigger = 4'b0001; step();
      check("and_b0", 32'(state), 32'd2);
      trigger = 4'b0010; step();
      check("and_b1", 32'(state), 32'd2);
      trigger = 4'b0011; step();
      check("and_joint", 32'(state), 32'd3);
      trigger = '0;
      repeat (6) step();
      check("and_done", 32'(done), 32'd1);
      check("and_tpos", 32'(trig_pos), 32'd1);
      read_seq("and", 5);

      // zero mask never triggers
      trig_mask = '0;
      arm_cap(1);
      for (int i = 0; i < 16; i++) begin
         trigger = TW'(i);
         trig_and = i[3];
         step();
      end
      trigger = '0;
      check("mask0_state", 32'(state), 32'd2);
      check("mask0_done", 32'(done), 32'd0);

      // clock enable low for 4 cycles mid-POST
      trig_mask = 4'b0001; trig_and = 1'b0;
      arm_cap(2);
      step(); step();
      trigger = 4'b0001; step();
      trigger = '0;
      step(); step();
      check("cke_n_before", 32'(n_samples), 32'd5);
      cke = 1'b0;
      repeat (4) step();
      check("cke_n_hold", 32'(n_samples), 32'd5);
      check("cke_state_hold", 32'(state), 32'd3);
      cke = 1'b1;
      step(); step();
      check("cke_early", 32'(done), 32'd0);
      step();
      check("cke_done", 32'(done), 32'd1);
      exp_c = '{16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd12, 16'd13, 16'd14};
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rd_idx = BW'(i);
         step();
         check("cke_rdd", 32'(rd_data), 32'(exp_c[i]));
      end
      rd_en = 1'b0;

      // abort in POST, then arm+abort together, then a clean capture
      arm_cap(2);
      step(); step();
      trigger = 4'b0001; step();
      trigger = '0;
      step();
      abort = 1'b1; step(); abort = 1'b0;
      check("abort_state", 32'(state), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      step();
      check("abort_stay", 32'(state), 32'd0);
      pre_len = 3'd2;
      arm = 1'b1; abort = 1'b1;
      step();
      arm = 1'b0; abort = 1'b0;
      sig = 16'd3;
      check("armabort_pri", 32'(state), 32'd1);
      step(); step();
      trigger = 4'b0001; step();
      trigger = '0;
      repeat (4) step();
      check("rearm_early", 32'(done), 32'd0);
      step();
      check("rearm_done", 32'(done), 32'd1);
      read_seq("rearm", 3);

      // asynchronous reset in the middle of POST
      arm_cap(2);
      step(); step();
      trigger = 4'b0001; step();
      trigger = '0;
      rd_en = 1'b1; rd_idx = '0;
      step();
      rd_en = 1'b0;
      check("post_read_v", 32'(rd_valid), 32'd1);
      check("post_read_d", 32'(rd_data), 32'd0);
      check("post_tpos", 32'(trig_pos), 32'd2);
      #2 arst_n = 1'b0;
      #1;
      check("arst_state", 32'(state), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_nsamp", 32'(n_samples), 32'd0);
      check("arst_tpos", 32'(trig_pos), 32'd0);
      check("arst_rdv", 32'(rd_valid), 32'd0);
      check("arst_rdd", 32'(rd_data), 32'd0);
      #2 arst_n = 1'b1;
      step(); step();
      check("arst_after", 32'(state), 32'd0);
      check("arst_after_done", 32'(done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iob_ila_capture.md
IOB_ILA_CAPTURE -- requirements
Module: iob_ila_capture

Interface
REQ-001 SHALL have parameter SIGNAL_W, default 32: width of the sampled signal bus.
REQ-002 SHALL have parameter TRIGGER_W, default 4: number of trigger inputs.
REQ-003 SHALL have parameter BUFFER_W, default 8: log2 of buffer depth, so DEPTH = 2^BUFFER_W.
REQ-004 SHALL have parameter EDGE_EN, default 1: when 0, per-bit edge mode is disabled and every trigger bit behaves as level.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port arst_n_i, input, 1 bit: reset; already decided as asynchronous and active-low.
REQ-007 SHALL have port cke_i, input, 1 bit: clock enable; when 0, all state holds.
REQ-008 SHALL have port signal_i, input, SIGNAL_W bits: data to sample.
REQ-009 SHALL have port trigger_i, input, TRIGGER_W bits: raw trigger inputs.
REQ-010 SHALL have ports trig_type_i, trig_negate_i and trig_mask_i, input, TRIGGER_W bits each: per-bit mode (1 = edge, 0 = level), per-bit inversion, per-bit enable.
REQ-011 SHALL have port trig_and_i, input, 1 bit: trigger combine mode (1 = AND, 0 = OR).
REQ-012 SHALL have port pre_len_i, input, BUFFER_W bits: number of samples to keep before the trigger.
REQ-013 SHALL have ports arm_i and abort_i, input, 1 bit each: single-cycle control pulses.
REQ-014 SHALL have port state_o, output, 3 bits: FSM state code.
REQ-015 SHALL have port done_o, output, 1 bit: capture complete.
REQ-016 SHALL have port n_samples_o, output, BUFFER_W+1 bits: number of valid samples.
REQ-017 SHALL have port trig_pos_o, output, BUFFER_W bits: chronological index of the trigger sample.
REQ-018 SHALL have ports rd_en_i, input, 1 bit, and rd_idx_i, input, BUFFER_W bits: readout request and chronological index.
REQ-019 SHALL have ports rd_valid_o, output, 1 bit, and rd_data_o, output, SIGNAL_W bits: readout response.

Function
REQ-020 SHALL implement an FSM with states IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
REQ-021 SHALL register pre_len_i at arm, as PL = min(pre_len_i, DEPTH-1).
REQ-022 SHALL, on arm_i in any state, clear the write pointer, sample count and done_o, then enter PRE, or WAIT if PL=0.
REQ-023 SHALL, in PRE, WAIT and POST with cke_i=1, write signal_i to buf[wp] every cycle; wp increments mod DEPTH; the count saturates at DEPTH.
REQ-024 SHALL move PRE to WAIT on the cycle the PLth sample is written; triggers are ignored while in PRE.
REQ-025 SHALL compute the per-bit condition c = (type&EDGE_EN) ? (t & ~t_prev) : t, where t = trigger_i ^ negate and t_prev is registered every cke cycle from reset.
REQ-026 SHALL define hit as: AND mode, all masked bits have c=1; OR mode, any masked bit has c=1; a zero mask never hits.
REQ-027 SHALL, on hit in WAIT, store the sample of that cycle as the trigger sample, latch trig_addr=wp and enter POST.
REQ-028 SHALL, in POST, capture exactly DEPTH-PL-1 further samples and then enter DONE with done_o=1 in that same transition cycle; if DEPTH-PL-1=0, WAIT goes directly to DONE.
REQ-029 SHALL set trig_pos_o = min(PL, count before trigger) and define start = (trig_addr - trig_pos_o) mod DEPTH.
REQ-030 SHALL make a total capture of n_samples_o = trig_pos_o + DEPTH - PL ≤ DEPTH.
REQ-031 SHALL, for readout, register rd_data_o = buf[(start + rd_idx_i) mod DEPTH] with rd_valid_o=1 exactly one cycle after rd_en_i; back-to-back reads are allowed every cycle.
REQ-032 SHALL accept reads only in DONE; reads elsewhere give rd_valid_o=1 with rd_data_o=0.
REQ-033 SHALL, on abort_i, enter IDLE next cycle; done_o=0; buffer contents are undefined.
REQ-034 SHALL give arm_i priority when arm_i and abort_i are asserted together.
REQ-035 SHALL stop writes in DONE, holding all outputs until the next arm or abort.

Reset
REQ-036 SHALL, on arst_n_i low, immediately set state_o=IDLE, done_o=0, n_samples_o=0, trig_pos_o=0, rd_valid_o=0, rd_data_o=0, the pointers to 0 and t_prev=0; buffer contents are not reset.
REQ-037 SHALL, on reset mid-capture, abandon the capture and leave it unrecoverable.

Verification
REQ-038 SHALL cover: BUFFER_W=3, PL=2, OR level mask=1, counter as signal, trigger at sample 5 -> done; reads 0..7 give 3,4,5..10; trig_pos_o=2; n_samples_o=8.
REQ-039 SHALL cover: PL=0, edge trigger, trigger_i held high before arm -> no hit until a 0->1 edge; trigger sample at index 0.
REQ-040 SHALL cover: PL=5, trigger 3 cycles after WAIT is entered versus trigger held from arm -> hit is ignored in PRE; trig_pos_o=5 in both cases.
REQ-041 SHALL cover: AND mode, mask=0b0011, bits asserted on different cycles then together -> hit only on the joint cycle; mask=0 -> never done.
REQ-042 SHALL cover: abort in POST, then arm -> IDLE, then a clean new capture; assert arst_n_i low mid-POST -> all outputs are 0 asynchronously.
REQ-043 SHALL cover: cke_i=0 for 4 cycles during POST -> no samples are lost or duplicated, and n_samples_o is unchanged.
